// File: rtl/exp_job_scheduler.sv
// Round-robin front end that shares one series-evaluation engine among NREQ clients.
// Grants one job at a time, launches the engine, and returns its result or a watchdog abort.
module exp_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int XW      = 16,
    parameter int RW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*XW-1:0]       x_bus,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          done,
    output logic [RW-1:0]            result,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     eng_start,
    output logic [XW-1:0]            eng_x,
    input  logic                     eng_ready,
    input  logic [RW-1:0]            eng_result
);
    localparam int PW = $clog2(NREQ);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LO,
        WAIT_HI,
        DELIVER
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] cand_hi;
    logic [PW-1:0] cand_lo;
    logic          found_hi;
    logic [15:0]   wait_cnt;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        cand_hi  = '0;
        cand_lo  = '0;
        found_hi = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (PW'(i) > ptr) begin
                    cand_hi  = PW'(i);
                    found_hi = 1'b1;
                end else begin
                    cand_lo = PW'(i);
                end
            end
        end
        winner = found_hi ? cand_hi : cand_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ack       <= '0;
            done      <= '0;
            err       <= 1'b0;
            eng_start <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            eng_x     <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            ptr       <= PW'(NREQ - 1);
        end else begin
            ack       <= '0;
            done      <= '0;
            err       <= 1'b0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if ((|req) && eng_ready) begin
                        eng_x       <= x_bus[int'(winner)*XW +: XW];
                        owner       <= winner;
                        ptr         <= winner;
                        ack[winner] <= 1'b1;
                        eng_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (wait_cnt == WD_LIMIT) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!eng_ready) begin
                        state <= WAIT_HI;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WAIT_HI: begin
                    // The watchdog budget spans both wait phases; the count is not restarted.
                    if (wait_cnt == WD_LIMIT) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (eng_ready) begin
                        result      <= eng_result;
                        done[owner] <= 1'b1;
                        state       <= DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DELIVER: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
